// File: rtl/fpu_result_collector.sv
// ---------------------------------------------------------------------------
// fpu_result_collector
//
// Purpose:
//   Sits behind the 23-stage result delay line of the quad-core FPU. The
//   pipeline tail cannot be stalled, so every completed result is captured
//   into an in-order circular buffer. The head entry is offered to its
//   issuing core over a per-core valid/ready handshake. Every dequeue
//   returns one credit to the issue logic, which keeps the buffer from
//   overflowing. If a result has to be dropped anyway, this is latched in a
//   sticky overflow flag.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   pipeline tail carries a completed result (no backpressure)
//   in_core     in   issuing core id 0..3
//   in_tag      in   destination register tag
//   in_data     in   result value
//   in_flags    in   IEEE exception flags {NV,DZ,OF,UF,NX}
//   out_valid   out  one-hot, bit k set when the head belongs to core k
//   out_tag     out  head tag (shared by all cores)
//   out_data    out  head data
//   out_flags   out  head flags
//   out_ready   in   per-core accept; only the head core's bit is used
//   credit_ret  out  one-cycle pulse, one cycle after each dequeue
//   count       out  current occupancy 0..DEPTH
//   overflow    out  sticky, set when a result was dropped
// ---------------------------------------------------------------------------
module fpu_result_collector #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [1:0]                 in_core,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [4:0]                 in_flags,
    output logic [3:0]                 out_valid,
    output logic [TAG_W-1:0]           out_tag,
    output logic [DATA_W-1:0]          out_data,
    output logic [4:0]                 out_flags,
    input  logic [3:0]                 out_ready,
    output logic                       credit_ret,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage is split per field; none of it is reset, only the pointers
    // and occupancy decide what is meaningful.
    logic [1:0]        coreMem  [DEPTH];
    logic [TAG_W-1:0]  tagMem   [DEPTH];
    logic [DATA_W-1:0] dataMem  [DEPTH];
    logic [4:0]        flagsMem [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          credit_q, credit_d;
    logic          overflow_q, overflow_d;

    logic       empty;
    logic       full;
    logic [1:0] headCore;
    logic       pop;
    logic       push;

    // Head decode and handshake. The pop decision uses only the ready bit
    // of the core owning the head, so a stalled core blocks everyone behind
    // it; the credit scheme on the issue side makes that acceptable.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        headCore = coreMem[rdPtr_q];
        pop      = !empty && out_ready[headCore];
        push     = in_valid && (!full || pop);
    end

    // Next-state for pointers, occupancy, credit pulse and the sticky flag.
    // A simultaneous push and pop when full is legal because the slot being
    // freed is the one at rd_ptr while the write lands at wr_ptr == rd_ptr
    // after the edge; the read side has already consumed it this cycle.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        credit_d   = pop;
        overflow_d = overflow_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (in_valid && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register; reset discards all buffered entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            coreMem[wrPtr_q]  <= in_core;
            tagMem[wrPtr_q]   <= in_tag;
            dataMem[wrPtr_q]  <= in_data;
            flagsMem[wrPtr_q] <= in_flags;
        end
    end

    // Outputs come straight from registered state; out_valid never looks at
    // out_ready and nothing looks at in_*.
    always_comb begin
        out_valid  = empty ? 4'b0000 : (4'b0001 << headCore);
        out_tag    = tagMem[rdPtr_q];
        out_data   = dataMem[rdPtr_q];
        out_flags  = flagsMem[rdPtr_q];
        credit_ret = credit_q;
        count      = count_q;
        overflow   = overflow_q;
    end

endmodule
